// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types and constants for the 7-segment display scheduler
package seg_display_pkg;

  localparam int SEG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    BLANK
  } seg_sched_state_t;

endpackage

// File: rtl/seg_rr_arbiter.sv
// rtl/seg_rr_arbiter.sv - combinational round-robin pick starting after the last served source
module seg_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] winner
);

  localparam int IW = $clog2(N);

  // Scan from the farthest candidate back to last+1 so the nearest requester overwrites the rest.
  always_comb begin
    int            j;
    logic [IW-1:0] idx;
    any    = |req;
    winner = last;
    j      = 0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      j   = (int'(last) + k) % N;
      idx = IW'(j);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - round-robin sharing of one 8-digit display between requesters
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_SRC-1:0]                    req,
  input  logic [NUM_SRC-1:0][SEG_WORD_W-1:0]    req_data,
  input  logic                                  hold,
  output logic [NUM_SRC-1:0]                    grant,
  output logic [SEG_WORD_W-1:0]                 disp_data,
  output logic [$clog2(NUM_SRC)-1:0]            disp_src,
  output logic                                  disp_blank
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0]      BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0   = NUM_SRC'(1);

  seg_sched_state_t       state_q, state_d;
  logic [IW-1:0]          sel_q, sel_d;
  logic [IW-1:0]          last_q, last_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [NUM_SRC-1:0]     grant_d;
  logic [SEG_WORD_W-1:0]  data_d;
  logic [IW-1:0]          src_d;
  logic                   blank_d;
  logic                   any;
  logic [IW-1:0]          winner;

  seg_rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req    (req),
    .last   (last_q),
    .any    (any),
    .winner (winner)
  );

  // State, counters and every output are registered together so outputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= IW'(NUM_SRC - 1);
      dwell_q    <= '0;
      bcnt_q     <= '0;
      grant      <= '0;
      disp_data  <= '0;
      disp_src   <= '0;
      disp_blank <= 1'b1;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      dwell_q    <= dwell_d;
      bcnt_q     <= bcnt_d;
      grant      <= grant_d;
      disp_data  <= data_d;
      disp_src   <= src_d;
      disp_blank <= blank_d;
    end
  end

  // Next-state logic; grant_d is only raised on transitions into LOAD so grant lasts one cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    bcnt_d  = bcnt_q;
    grant_d = '0;
    data_d  = disp_data;
    src_d   = disp_src;
    blank_d = disp_blank;
    case (state_q)
      IDLE: begin
        blank_d = 1'b1;
        if (any) begin
          state_d = LOAD;
          sel_d   = winner;
          grant_d = ONE_HOT0 << winner;
        end
      end
      LOAD: begin
        // Capture regardless of whether the requester is still asking.
        data_d  = req_data[sel_q];
        src_d   = sel_q;
        last_d  = sel_q;
        blank_d = 1'b0;
        dwell_d = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (!hold) begin
          if (dwell_q == DWELL_LAST) begin
            if (!any) begin
              dwell_d = '0;
            end else if (req == (ONE_HOT0 << disp_src)) begin
              state_d = LOAD;
              sel_d   = disp_src;
              grant_d = ONE_HOT0 << disp_src;
            end else begin
              state_d = BLANK;
              blank_d = 1'b1;
              bcnt_d  = '0;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          if (any) begin
            state_d = LOAD;
            sel_d   = winner;
            grant_d = ONE_HOT0 << winner;
          end else begin
            state_d = SHOW;
            blank_d = 1'b0;
            dwell_d = '0;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
